// File: rtl/bram_block_reader.sv
// Reads a DEPTH-word block from BRAM port B and streams it out through a credit-controlled skid FIFO.
// Optional data checker against the writer's pattern is built when BRAMREAD_CHECK_EN is defined.
module bram_block_reader #(
  parameter logic [31:0] ADDR_BASE    = 32'h4000_0000,
  parameter int          DEPTH        = 16,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk40,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] addrb,
  output logic        clkb,
  output logic [31:0] dinb,
  output logic        enb,
  output logic        rstb,
  output logic [3:0]  web,
  input  logic [31:0] doutb,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] err_count,
  output logic        mismatch
);

  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]   LAST_IDX   = 16'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX    = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic done_q, done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] mem_d [FIFO_DEPTH];
  logic last_mem_q [FIFO_DEPTH];
  logic last_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;

  logic [CW-1:0] in_flight;
  logic [CW:0]   credit_sum;
  logic issue, push, pop, start_accept;

  assign clkb  = clk40;
  assign dinb  = 32'h0;
  assign rstb  = 1'b0;
  assign web   = 4'b0000;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign enb   = issue;
  assign addrb = ADDR_BASE + {16'h0, idx_q};

  assign m_tvalid = (fifo_count_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign m_tlast  = m_tvalid && last_mem_q[rd_ptr_q];

  assign start_accept = (state_q == IDLE) && start;
  assign push = vld_q[READ_LATENCY-1];
  assign pop  = m_tvalid && m_tready;

  // Credit counts everything issued but not yet popped; a same-cycle pop is deliberately not credited.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CW'(vld_q[i]);
    end
  end

  assign credit_sum = {1'b0, fifo_count_q} + {1'b0, in_flight};
  assign issue = (state_q == READ) && (credit_sum < CREDIT_MAX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        if (issue) begin
          idx_d = idx_q + 16'd1;
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each issue travels down the latency pipe with a flag marking the final word of the block.
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = issue;
    tag_d[0] = issue && (idx_q == LAST_IDX);
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    mem_d        = mem_q;
    last_mem_d   = last_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      mem_d[wr_ptr_q]      = doutb;
      last_mem_d[wr_ptr_q] = tag_q[READ_LATENCY-1];
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      done_q       <= 1'b0;
      vld_q        <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]      <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      vld_q        <= vld_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      mem_q        <= mem_d;
      last_mem_q   <= last_mem_d;
    end
  end

`ifdef BRAMREAD_CHECK_EN
  logic [3:0]  pop_idx_q, pop_idx_d;
  logic [15:0] err_q, err_d;
  logic        mis_q, mis_d;

  // Popped words are checked in order, so a 4-bit beat counter reproduces the writer's pattern.
  always_comb begin
    pop_idx_d = pop_idx_q;
    err_d     = err_q;
    mis_d     = mis_q;
    if (start_accept) begin
      pop_idx_d = '0;
      err_d     = '0;
      mis_d     = 1'b0;
    end else if (pop) begin
      pop_idx_d = pop_idx_q + 4'd1;
      if (m_tdata != {28'h0, pop_idx_q}) begin
        mis_d = 1'b1;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      pop_idx_q <= '0;
      err_q     <= '0;
      mis_q     <= 1'b0;
    end else begin
      pop_idx_q <= pop_idx_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign err_count = err_q;
  assign mismatch  = mis_q;
`else
  assign err_count = 16'h0;
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_bram_block_reader.sv
// Scoreboard bench for bram_block_reader: a default-parameter instance with a 2-cycle BRAM model,
// plus a DEPTH=1 instance exercising back-to-back single-beat blocks with start held high.
module tb_bram_block_reader;

  localparam logic [31:0] ADDR_BASE = 32'h4000_0000;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk40 = 1'b0;
  logic resetn = 1'b0;

  logic        start1 = 1'b0, busy1, done1, clkb1, enb1, rstb1;
  logic [31:0] addrb1, dinb1, m_tdata1;
  logic [31:0] doutb1 = 32'h0;
  logic [3:0]  web1;
  logic        m_tvalid1, m_tlast1, mismatch1;
  logic        m_tready1 = 1'b1;
  logic [15:0] err_count1;

  logic        start2 = 1'b0, busy2, done2, clkb2, enb2, rstb2;
  logic [31:0] addrb2, dinb2, m_tdata2;
  logic [31:0] doutb2 = 32'h0;
  logic [3:0]  web2;
  logic        m_tvalid2, m_tlast2, mismatch2;
  logic        m_tready2 = 1'b1;
  logic [15:0] err_count2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int issued = 0, popped = 0, done_seen = 0;
  int first_valid_rel = -1, last_rel = -1, done_rel = -1;
  int beats2 = 0, dones2 = 0, beats_since_done2 = 0;
  bit prev_done_start2 = 1'b0;
  exp_t exp_q[$];
  exp_t e;

  logic [31:0] bram1 [16];
  logic [31:0] rd_pipe1 = 32'h0, rd_pipe2 = 32'h0;
  logic [31:0] sel1, sel2;

  always #5 clk40 = ~clk40;
  always @(posedge clk40) cyc <= cyc + 1;

  bram_block_reader #(.ADDR_BASE(ADDR_BASE), .DEPTH(16), .READ_LATENCY(2)) dut (
    .clk40(clk40), .resetn(resetn), .start(start1), .busy(busy1), .done(done1),
    .addrb(addrb1), .clkb(clkb1), .dinb(dinb1), .enb(enb1), .rstb(rstb1), .web(web1),
    .doutb(doutb1), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready1),
    .m_tlast(m_tlast1), .err_count(err_count1), .mismatch(mismatch1)
  );

  bram_block_reader #(.ADDR_BASE(ADDR_BASE), .DEPTH(1), .READ_LATENCY(2)) dut_d1 (
    .clk40(clk40), .resetn(resetn), .start(start2), .busy(busy2), .done(done2),
    .addrb(addrb2), .clkb(clkb2), .dinb(dinb2), .enb(enb2), .rstb(rstb2), .web(web2),
    .doutb(doutb2), .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready2),
    .m_tlast(m_tlast2), .err_count(err_count2), .mismatch(mismatch2)
  );

  // Two-stage BRAM read model: address registered on enb, data one cycle later.
  assign sel1 = addrb1 - ADDR_BASE;
  assign sel2 = addrb2 - ADDR_BASE;
  always @(posedge clk40) begin
    if (enb1) rd_pipe1 <= bram1[sel1[3:0]];
    doutb1 <= rd_pipe1;
    if (enb2) rd_pipe2 <= {28'h0, sel2[3:0]};
    doutb2 <= rd_pipe2;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{data: bram1[i], last: (i == 15)});
    end
    issued = 0;
    popped = 0;
    first_valid_rel = -1;
    last_rel = -1;
    done_rel = -1;
    @(posedge clk40); #1;
    start1 = 1'b1;
    start_cyc = cyc;
    @(posedge clk40); #1;
    start1 = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, input bit toggle);
    int base = done_seen;
    int c = 0;
    while (done_seen == base && c < budget) begin
      @(posedge clk40); #1;
      if (toggle) m_tready1 = ~m_tready1;
      c++;
    end
    m_tready1 = 1'b1;
    checkOutput({tag, "_done_count"}, done_seen - base, 1);
    checkOutput({tag, "_words_popped"}, popped, 16);
    checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic checkCycleOne(input string tag);
    @(negedge clk40);
    checkOutput({tag, "_c1_busy"}, busy1, 1);
    checkOutput({tag, "_c1_enb"}, enb1, 1);
    checkOutput({tag, "_c1_addrb"}, addrb1, ADDR_BASE);
    checkOutput({tag, "_c1_err_clear"}, err_count1, 0);
  endtask

  // Monitor: credit rule, addresses, and scoreboard pops for the DEPTH=16 instance.
  always @(negedge clk40) begin
    if (resetn) begin
      if (busy1 && issued < 16) checkOutput("enb_credit", enb1, ((issued - popped) < 4) ? 1 : 0);
      if (enb1) begin
        checkOutput("addrb", addrb1, ADDR_BASE + issued);
        issued++;
      end
      if (m_tvalid1 && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (m_tvalid1 && m_tready1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat data=%0h expected no beat", m_tdata1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", m_tdata1, e.data);
          checkOutput("beat_last", m_tlast1, e.last);
        end
        if (m_tlast1) last_rel = cyc - start_cyc;
        popped++;
      end
      if (done1) begin
        done_rel = cyc - start_cyc;
        checkOutput("done_busy_low", busy1, 0);
        done_seen++;
      end
    end
  end

  // Monitor for the DEPTH=1 instance.
  always @(negedge clk40) begin
    if (resetn) begin
      if (prev_done_start2) checkOutput("d1_restart_busy", busy2, 1);
      prev_done_start2 = done2 && start2;
      if (m_tvalid2 && m_tready2) begin
        checkOutput("d1_last", m_tlast2, 1);
        checkOutput("d1_data", m_tdata2, 0);
        beats2++;
        beats_since_done2++;
      end
      if (done2) begin
        checkOutput("d1_beats_per_block", beats_since_done2, 1);
        beats_since_done2 = 0;
        dones2++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit held;
    int base;
    for (int i = 0; i < 16; i++) bram1[i] = i & 32'hF;

    repeat (3) @(posedge clk40);
    @(negedge clk40);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_done", done1, 0);
    checkOutput("rst_enb", enb1, 0);
    checkOutput("rst_addrb", addrb1, ADDR_BASE);
    checkOutput("rst_tvalid", m_tvalid1, 0);
    checkOutput("rst_tlast", m_tlast1, 0);
    checkOutput("rst_tdata", m_tdata1, 0);
    checkOutput("rst_err", err_count1, 0);
    checkOutput("rst_mismatch", mismatch1, 0);
    checkOutput("tie_dinb", dinb1, 0);
    checkOutput("tie_rstb_web", {rstb1, web1}, 0);
    checkOutput("tie_clkb", clkb1, clk40);
    @(posedge clk40); #1;
    resetn = 1'b1;

    // Full-rate block with the exact latency landmarks.
    applyStimulus();
    checkCycleOne("t1");
    waitDone("t1", 60, 1'b0);
    checkOutput("t1_first_valid_cycle", first_valid_rel, 4);
    checkOutput("t1_last_cycle", last_rel, 19);
    checkOutput("t1_done_cycle", done_rel, 20);
    checkOutput("t1_err", err_count1, 0);

    // Ready toggling every cycle.
    applyStimulus();
    waitDone("t2", 120, 1'b1);

    // Ready held low for 20 cycles: four reads issued, head word held.
    m_tready1 = 1'b0;
    applyStimulus();
    held = 1'b1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk40);
      if (m_tvalid1 && m_tdata1 !== 32'h0) held = 1'b0;
      @(posedge clk40); #1;
    end
    @(negedge clk40);
    checkOutput("t3_reads_issued", issued, 4);
    checkOutput("t3_tvalid", m_tvalid1, 1);
    checkOutput("t3_tdata", m_tdata1, 0);
    checkOutput("t3_held", held, 1);
    @(posedge clk40); #1;
    m_tready1 = 1'b1;
    waitDone("t3", 60, 1'b0);

    // Word 5 corrupted.
    bram1[5] = 32'hDEAD;
    applyStimulus();
    waitDone("t4", 60, 1'b0);
`ifdef BRAMREAD_CHECK_EN
    checkOutput("t4_err_count", err_count1, 1);
    checkOutput("t4_mismatch", mismatch1, 1);
`else
    checkOutput("t4_err_count", err_count1, 0);
    checkOutput("t4_mismatch", mismatch1, 0);
`endif
    bram1[5] = 32'h5;

    // Reset at cycle 8 of a block; the accepted start also clears the checker.
    applyStimulus();
    checkCycleOne("t5");
    repeat (6) @(posedge clk40);
    #1;
    resetn = 1'b0;
    base = done_seen;
    @(posedge clk40); #1;
    checkOutput("t5_busy", busy1, 0);
    checkOutput("t5_done", done1, 0);
    checkOutput("t5_enb", enb1, 0);
    checkOutput("t5_addrb", addrb1, ADDR_BASE);
    checkOutput("t5_tvalid", m_tvalid1, 0);
    checkOutput("t5_tlast", m_tlast1, 0);
    checkOutput("t5_tdata", m_tdata1, 0);
    checkOutput("t5_err", {15'h0, mismatch1, err_count1}, 0);
    exp_q.delete();
    issued = 0;
    popped = 0;
    @(posedge clk40); #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk40);
    #1;
    checkOutput("t5_no_done", done_seen - base, 0);
    applyStimulus();
    checkCycleOne("t6");
    waitDone("t6", 60, 1'b0);

    // DEPTH=1 instance with start held high.
    beats2 = 0;
    dones2 = 0;
    beats_since_done2 = 0;
    @(posedge clk40); #1;
    start2 = 1'b1;
    repeat (40) @(posedge clk40);
    #1;
    start2 = 1'b0;
    checkOutput("d1_done_count", dones2, 7);
    checkOutput("d1_beat_count", beats2, 8);
    repeat (10) @(posedge clk40);
    #1;
    checkOutput("d1_idle", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
